replay_ctrl: RTL
================

Name: replay_ctrl

Overview:
- Write/replay controller sitting directly upstream of the 8x16 single-clock buffer RAM (one write port, one registered read port, output enable).
- Accepts a valid/ready input stream and writes it circularly into the RAM, always keeping the most recent DEPTH entries.
- On a replay request it streams every stored entry back, oldest first, and compensates for the RAM's one-cycle read latency.
- Guarantees the RAM write enable is never high while the RAM read data is being consumed, because the RAM tristates dout whenever we=1.

Parameters:
- DATA_W, 16: data word width.
- ADDR_W, 3: RAM address width.
- DEPTH, 8: number of entries; must equal 2**ADDR_W.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- in_valid, input, 1: input word valid.
- in_data, input, DATA_W: input word.
- in_ready, output, 1: controller can accept a word.
- clear, input, 1: synchronous logical flush; empties the buffer.
- replay_req, input, 1: one-cycle request to replay the buffer contents.
- replay_busy, output, 1: replay in progress.
- out_valid, output, 1: out_data holds a replayed word.
- out_data, output, DATA_W: replayed word.
- count, output, ADDR_W+1: number of stored entries, 0..DEPTH.
- ram_we, output, 1: RAM write enable.
- ram_w_addr, output, ADDR_W: RAM write address.
- ram_din, output, DATA_W: RAM write data.
- ram_oe, output, 1: RAM output enable.
- ram_r_addr, output, ADDR_W: RAM read address.
- ram_dout, input, DATA_W: RAM registered read data.

Behaviour:
- Reset values (applied immediately while rst_n=0):
  - state=IDLE, wr_ptr=0, count=0, rd_ptr=0, remaining=0.
  - out_valid=0, replay_busy=0, ram_oe=0, ram_r_addr=0.
  - ram_we=0 follows from in_ready being low during reset.
- States:
  - IDLE: accepting input.
  - READ: issuing read addresses.
  - DRAIN: one cycle to present the last word.
- in_ready = (state==IDLE) and rst_n.
- Write path:
  - ram_we = in_valid & in_ready (combinational); ram_w_addr = wr_ptr; ram_din = in_data.
  - On an accepted write: wr_ptr increments modulo DEPTH and count = min(count+1, DEPTH).
  - Once full, a new write overwrites the oldest entry and count stays at DEPTH.
- Oldest entry address = (wr_ptr - count) modulo DEPTH.
- clear:
  - Honoured only in IDLE: sets count=0; wr_ptr is unchanged.
  - If a write is accepted in the same cycle, clear wins for the existing entries and the new write is retained, giving count=1.
  - Ignored while replay_busy is high.
- Entering replay:
  - IDLE with replay_req=1, count_next>0 and no clear: go to READ at the next edge.
  - count_next includes any write accepted in that same cycle.
  - On entry, rd_ptr = oldest entry address and remaining = count_next.
  - If replay_req=1 and count_next=0, the request is ignored.
  - replay_req while busy is ignored.
- READ, each cycle:
  - ram_r_addr = rd_ptr.
  - At the edge: rd_ptr increments modulo DEPTH and remaining decrements.
  - When remaining==1 at the edge, go to DRAIN.
- DRAIN: lasts one cycle, then IDLE.
- Read data path:
  - issued_q is a register set at each edge where state was READ.
  - out_valid = issued_q; out_data = ram_dout, passed through combinationally.
- Outputs during replay:
  - replay_busy = (state != IDLE).
  - ram_oe = replay_busy.
  - ram_we is 0 throughout, because in_ready is low.
- Timing for N entries, with replay_req in cycle 0:
  - READ occupies cycles 1..N; DRAIN is cycle N+1.
  - out_valid is high in cycles 2..N+1, contiguous.
  - IDLE and in_ready=1 return in cycle N+2.
- There is no output backpressure: the consumer must take every out_valid word.
- count and the stored data are unchanged by a replay, so a replay can be repeated.
- Reset mid-replay:
  - Everything returns to reset values asynchronously, and out_valid drops immediately.
  - The buffer is logically empty afterwards (count=0). RAM contents are not erased but are unreachable.

Test Plan:
- Reset: assert rst_n=0 mid-simulation -> out_valid, replay_busy, ram_oe, ram_we and count are all 0 without waiting for a clock edge; in_ready=1 after release.
- Basic replay: write 0x000A, 0x0014, 0x001E, then pulse replay_req in cycle 0 -> out_valid high in cycles 2, 3, 4 carrying 0x000A, 0x0014, 0x001E; replay_busy high in cycles 1-4; count stays 3.
- Wrap and overwrite: write 1..10 -> count=8 and wr_ptr=2; replay -> 8 words 3,4,...,10 in order; replaying again gives the identical sequence.
- Empty and ignored requests:
  - replay_req with count=0 -> replay_busy and out_valid stay 0.
  - replay_req pulsed during a replay -> no extra words and no restart.
- Input blocking: hold in_valid=1 through a replay of 4 entries -> in_ready=0 and ram_we=0 whenever ram_oe=1; the pending word is written in the first IDLE cycle.
- Simultaneous events:
  - Write 0x0063 in the same cycle as replay_req with count=2 -> 3 words replayed, ending with 0x0063.
  - clear together with a write of 0x0005 -> count=1; replay yields only 0x0005.
- Reset mid-replay: pull rst_n low in cycle 3 of an 8-entry replay -> out_valid drops immediately, count=0; a subsequent replay_req produces no output.

Source files
------------

// File: rtl/replay_ctrl.sv
// replay_ctrl: circular write / oldest-first replay controller that sits in
// front of a single-clock buffer RAM with a registered read port. The RAM
// write enable is held low for the whole replay, because the RAM releases
// its data bus whenever a write is in progress.
module replay_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              clear,
  input  logic              replay_req,
  output logic              replay_busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   count,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_oe,
  output logic [ADDR_W-1:0] ram_r_addr,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_CNT  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_PTR  = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              issued_q, issued_d;
  logic              is_idle;
  logic              accept;

  assign is_idle     = (state_q == IDLE);
  assign in_ready    = is_idle & rst_n;
  assign accept      = in_valid & in_ready;

  assign ram_we      = accept;
  assign ram_w_addr  = wr_ptr_q;
  assign ram_din     = in_data;
  assign ram_r_addr  = rd_ptr_q;

  assign replay_busy = ~is_idle;
  assign ram_oe      = ~is_idle;
  assign out_valid   = issued_q;
  assign out_data    = ram_dout;
  assign count       = count_q;

  // Next-state logic: write bookkeeping, clear, and the replay sequencer.
  // The replay start pointer uses the post-write pointer and count so a word
  // accepted in the request cycle is included as the newest entry.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    issued_d    = (state_q == READ);

    if (accept) begin
      wr_ptr_d = wr_ptr_q + ONE_PTR;
    end

    if (is_idle) begin
      if (clear) begin
        count_d = accept ? ONE_CNT : '0;
      end else if (accept && (count_q != FULL_CNT)) begin
        count_d = count_q + ONE_CNT;
      end
    end

    case (state_q)
      IDLE: begin
        if (replay_req && !clear && (count_d != '0)) begin
          state_d     = READ;
          rd_ptr_d    = wr_ptr_d - count_d[ADDR_W-1:0];
          remaining_d = count_d;
        end
      end
      READ: begin
        rd_ptr_d    = rd_ptr_q + ONE_PTR;
        remaining_d = remaining_q - ONE_CNT;
        if (remaining_q == ONE_CNT) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset drops everything, including out_valid, at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      issued_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      issued_q    <= issued_d;
    end
  end

endmodule
